apb_rr_master: RTL and testbench

Two-port round-robin APB master that serialises accesses from two independent requesters (e.g. CPU-side register port and DMA/test port) onto one APB slave such as the 8-entry APB register memory. It owns the SETUP/ACCESS sequencing (PSEL/PENABLE), arbitrates fairly between requesters, returns read data and completion per requester, and aborts transfers whose PREADY never arrives.

---
 rtl/apb_rr_master.sv | 145 ++++++++++++++
 tb/tb_apb_rr_master.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_rr_master.sv
// apb_rr_master: two-requester round-robin APB master.
// Serialises requests from two ports onto one APB slave, sequences
// SETUP/ACCESS, returns per-requester completion and read data, and aborts
// an ACCESS phase that sees no PREADY within TIMEOUT wait cycles.
module apb_rr_master #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [1:0]        wr,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [1:0]        done,
    output logic              err,
    output logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t            r_state;
    state_t            w_next;
    logic              r_last_grant;
    logic              r_grant;
    logic [7:0]        r_wait;
    logic [1:0]        r_done;
    logic              r_err;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] r_paddr;
    logic              r_pwrite;
    logic [DATA_W-1:0] r_pwdata;

    logic [1:0]        w_elig;
    logic              w_pick;
    logic              w_start;
    logic              w_complete;
    logic              w_timeout;

    // Requester whose done is pulsing this cycle sits out one arbitration round;
    // on a tie the requester that did not win last time is chosen.
    always_comb begin
        w_elig = req & ~r_done;
        w_pick = (w_elig == 2'b11) ? ~r_last_grant : w_elig[1];
    end

    // State register; async reset also drops PSEL/PENABLE immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state and APB phase decode.
    always_comb begin
        w_next     = r_state;
        w_start    = 1'b0;
        w_complete = 1'b0;
        w_timeout  = 1'b0;
        PSEL       = 1'b0;
        PENABLE    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|w_elig) begin
                    w_start = 1'b1;
                    w_next  = S_SETUP;
                end
            end
            S_SETUP: begin
                PSEL   = 1'b1;
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                if (PREADY) begin
                    w_complete = 1'b1;
                    w_next     = S_IDLE;
                end else if (r_wait == TIMEOUT_CNT) begin
                    w_timeout = 1'b1;
                    w_next    = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Grant capture, wait counter and per-requester completion/read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_wait       <= 8'd0;
            r_done       <= 2'b00;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            r_paddr      <= '0;
            r_pwrite     <= 1'b0;
            r_pwdata     <= '0;
        end else begin
            r_done <= 2'b00;
            r_err  <= 1'b0;
            if (w_start) begin
                r_paddr      <= w_pick ? addr1 : addr0;
                r_pwdata     <= w_pick ? wdata1 : wdata0;
                r_pwrite     <= wr[w_pick];
                r_grant      <= w_pick;
                r_last_grant <= w_pick;
            end
            if (r_state == S_SETUP) begin
                r_wait <= 8'd0;
            end else if (r_state == S_ACCESS && !PREADY) begin
                r_wait <= r_wait + 8'd1;
            end
            if (w_complete || w_timeout) begin
                r_done[r_grant] <= 1'b1;
                r_err           <= w_timeout;
                if (!r_pwrite) r_rdata <= w_timeout ? '0 : PRDATA;
            end
        end
    end

    assign done   = r_done;
    assign err    = r_err;
    assign rdata  = r_rdata;
    assign PADDR  = r_paddr;
    assign PWRITE = r_pwrite;
    assign PWDATA = r_pwdata;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master with a small 8-entry APB slave model
// that can insert wait states or hold PREADY low.
module tb_apb_rr_master;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [1:0]        req;
    logic [1:0]        wr;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic [1:0]        done;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] PADDR;
    logic              PSEL, PENABLE, PWRITE;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    logic              PREADY;

    int n_chk = 0;
    int n_bad = 0;

    // slave model controls
    logic              stuck = 1'b0;
    int                nwait = 0;
    logic              rd_fix = 1'b0;
    int                acnt = 0;
    logic [DATA_W-1:0] mem [8];

    // monitors
    int                both_seen = 0;
    int                stab_bad = 0;
    logic [ADDR_W+DATA_W:0] cap;

    apb_rr_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .req(req), .wr(wr),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done(done), .err(err), .rdata(rdata),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    always #5 clk = ~clk;

    assign PREADY = !stuck && (acnt >= nwait);
    assign PRDATA = rd_fix ? 32'h0000_1234 : mem[PADDR[2:0]];

    always @(posedge clk) begin
        acnt <= (PSEL && PENABLE) ? acnt + 1 : 0;
        if (PSEL && PENABLE && PREADY && PWRITE) mem[PADDR[2:0]] <= PWDATA;
    end

    always @(negedge clk) begin
        if (done == 2'b11) both_seen++;
        if (PSEL && !PENABLE) cap = {PADDR, PWRITE, PWDATA};
        else if (PSEL && PENABLE && cap != {PADDR, PWRITE, PWDATA}) stab_bad++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Raise req, count cycles to the done pulse, count ACCESS cycles seen.
    task automatic xfer(input logic [1:0] rq, input int maxc,
                        output int cyc, output int acc, output logic [1:0] d);
        @(negedge clk);
        while (done != 2'b00) @(negedge clk);
        req = rq;
        cyc = 0;
        acc = 0;
        d   = 2'b00;
        while (d == 2'b00 && cyc < maxc) begin
            @(posedge clk);
            #1;
            cyc++;
            if (PSEL && PENABLE) acc++;
            d = done;
        end
        req = 2'b00;
        chk("done_within_bound", {63'd0, d != 2'b00}, 64'd1);
    endtask

    initial begin
        int cyc, acc, got, ccyc;
        logic [1:0] d;
        logic [1:0] seq [4];
        logic [DATA_W-1:0] rd0;
        logic [1:0] dseen;

        for (int i = 0; i < 8; i++) mem[i] = '0;
        reset  = 1'b0;
        req    = 2'b11;
        wr     = 2'b11;
        addr0  = 32'd3;  wdata0 = 32'h0000_00A5;
        addr1  = 32'd5;  wdata1 = 32'h0000_005A;

        // reset held with both requests active
        repeat (3) @(negedge clk);
        chk("rst_psel", PSEL, 0);
        chk("rst_penable", PENABLE, 0);
        chk("rst_done", done, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_paddr", PADDR, 0);
        req   = 2'b00;
        reset = 1'b1;

        // tie after reset: requester 0 first, write 0xA5 to addr 3, 3 cycles
        xfer(2'b11, 30, cyc, acc, d);
        chk("first_grant_done", d, 2'b01);
        chk("wr_latency", cyc, 3);
        chk("wr_err", err, 0);
        chk("wr_rdata_unchanged", rdata, 0);

        // read back addr 3 from requester 0
        wr = 2'b00;
        xfer(2'b01, 30, cyc, acc, d);
        chk("rd_done", d, 2'b01);
        chk("rd_latency", cyc, 3);
        chk("rd_data", rdata, 32'hA5);

        // contention: req0 reads addr 3, req1 writes addr 5; last winner was 0
        @(negedge clk);
        while (done != 2'b00) @(negedge clk);
        wr = 2'b10;
        addr1 = 32'd5; wdata1 = 32'h0000_5A5A;
        req = 2'b11;
        got = 0; ccyc = 0; rd0 = '0;
        while (got < 4 && ccyc < 60) begin
            @(posedge clk);
            #1;
            ccyc++;
            if (done != 2'b00) begin
                seq[got] = done;
                if (done == 2'b01) rd0 = rdata;
                got++;
            end
        end
        req = 2'b00;
        chk("cont_count", got, 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("cont_order%0d", i), seq[i], (i % 2 == 0) ? 2'b10 : 2'b01);
        chk("cont_rdata", rd0, 32'hA5);
        chk("cont_mem5", mem[5], 32'h5A5A);

        // three wait states, fixed read data
        nwait = 3; rd_fix = 1'b1;
        addr0 = 32'd2; wr = 2'b00;
        xfer(2'b01, 30, cyc, acc, d);
        chk("wait_done", d, 2'b01);
        chk("wait_latency", cyc, 6);
        chk("wait_access_cycles", acc, 4);
        chk("wait_rdata", rdata, 32'h1234);
        chk("wait_err", err, 0);
        nwait = 0; rd_fix = 1'b0;

        // PREADY stuck low: abort after TIMEOUT+1 ACCESS cycles
        stuck = 1'b1;
        addr0 = 32'd3; wr = 2'b00;
        xfer(2'b01, 60, cyc, acc, d);
        chk("to_done", d, 2'b01);
        chk("to_err", err, 1);
        chk("to_rdata", rdata, 0);
        chk("to_access_cycles", acc, TIMEOUT + 1);
        chk("to_latency", cyc, TIMEOUT + 3);
        stuck = 1'b0;

        // normal transfer afterwards
        addr1 = 32'd6; wdata1 = 32'h0000_0066; wr = 2'b10;
        xfer(2'b10, 30, cyc, acc, d);
        chk("post_to_done", d, 2'b10);
        chk("post_to_err", err, 0);
        chk("post_to_latency", cyc, 3);
        chk("post_to_mem6", mem[6], 32'h66);

        // async reset during ACCESS
        @(negedge clk);
        while (done != 2'b00) @(negedge clk);
        addr0 = 32'd1; wr = 2'b00;
        req = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_in_access", {PSEL, PENABLE}, 2'b11);
        #2 reset = 1'b0;
        #1;
        chk("abort_psel", PSEL, 0);
        chk("abort_penable", PENABLE, 0);
        req = 2'b00;
        dseen = 2'b00;
        repeat (3) begin
            @(posedge clk); #1;
            dseen = dseen | done;
        end
        chk("abort_no_done", dseen, 0);
        @(negedge clk);
        reset = 1'b1;
        wr = 2'b00;
        xfer(2'b11, 30, cyc, acc, d);
        chk("abort_regrant0", d, 2'b01);

        chk("never_both_done", both_seen, 0);
        chk("apb_stable", stab_bad, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
